prog_fetch_rom: RTL and testbench

- Parametrised, loadable instruction store with a built-in fetch sequencer for the team's small accumulator CPU.
- Holds the program: each word is a 3-bit opcode in the top bits and an address/immediate field in the bottom bits.
- Runs a program counter from a start address and streams instructions to the datapath over a valid/ready handshake.
- Supports jumps, stops on the HALT word, and is reprogrammed through a load port while idle or halted.

---
 rtl/prog_fetch_pkg.sv | 25 ++
 rtl/prog_mem.sv | 37 +++
 rtl/prog_fetch_rom.sv | 146 ++++++++++++++
 tb/tb_prog_fetch_rom.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_fetch_pkg.sv
// Shared definitions for the program fetch ROM: opcode encodings, the
// sequencer state type and the HALT word generator.
package prog_fetch_pkg;

  localparam logic [2:0] OP_INPUT  = 3'b011;
  localparam logic [2:0] OP_OUTPUT = 3'b100;
  localparam logic [2:0] OP_DEC    = 3'b101;
  localparam logic [2:0] OP_JNZ    = 3'b110;
  localparam logic [2:0] OP_HALT   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } fetch_state_e;

  // All-ones word of the requested width, right-aligned in 64 bits.
  function automatic logic [63:0] halt_word(input int width);
    if (width >= 64) begin
      return '1;
    end
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/prog_mem.sv
// Program store: DEPTH x DATA_W register array, one synchronous write port
// that resets every word to HALT, one asynchronous read port.
module prog_mem
  import prog_fetch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [63:0]       HW64      = halt_word(DATA_W);
  localparam logic [DATA_W-1:0] HALT_WORD = HW64[DATA_W-1:0];

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= HALT_WORD;
      end
    end else if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  // Addresses past the populated range read back as HALT.
  assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : HALT_WORD;

endmodule

// File: rtl/prog_fetch_rom.sv
// Loadable instruction store with fetch sequencer: runs a PC from a start
// address and streams words over valid/ready until the HALT word is consumed.
module prog_fetch_rom
  import prog_fetch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              abort,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              err
);

  localparam logic [63:0]       HW64      = halt_word(DATA_W);
  localparam logic [DATA_W-1:0] HALT_WORD = HW64[DATA_W-1:0];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_p0, pc_d;
  logic [DATA_W-1:0] instr_p0, instr_d;
  logic              vld_p0, vld_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;

  logic              ld_ok, ld_bad;
  logic              start_go, handshake;
  logic [ADDR_W-1:0] seq_pc, next_pc, rd_addr;
  logic [DATA_W-1:0] rd_data, rd_fwd;

  assign ld_ok     = ld_we && (state_q != RUN) && in_range(ld_addr);
  assign ld_bad    = ld_we && !ld_ok;
  assign start_go  = start && !abort && (state_q != RUN);
  assign handshake = vld_p0 && instr_ready;

  assign seq_pc  = (pc_p0 == ADDR_W'(DEPTH - 1)) ? '0 : pc_p0 + ADDR_W'(1);
  assign next_pc = jmp_en ? jmp_addr : seq_pc;
  assign rd_addr = start_go ? start_addr : next_pc;

  prog_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (ld_ok),
    .waddr(ld_addr),
    .wdata(ld_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  // A word written in the same cycle it is fetched is forwarded.
  assign rd_fwd = (ld_ok && (ld_addr == rd_addr)) ? ld_data : rd_data;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_p0;
    instr_d  = instr_p0;
    vld_d    = vld_p0;
    halted_d = halted_q;
    err_d    = err_q;

    if (abort) begin
      state_d  = IDLE;
      vld_d    = 1'b0;
      halted_d = 1'b0;
    end else if (start_go) begin
      err_d    = 1'b0;
      halted_d = 1'b0;
      if (in_range(start_addr)) begin
        state_d = RUN;
        pc_d    = start_addr;
        instr_d = rd_fwd;
        vld_d   = 1'b1;
      end else begin
        state_d  = HALT;
        halted_d = 1'b1;
        err_d    = 1'b1;
        vld_d    = 1'b0;
      end
    end else if ((state_q == RUN) && handshake) begin
      if (instr_p0 == HALT_WORD) begin
        state_d  = HALT;
        vld_d    = 1'b0;
        halted_d = 1'b1;
      end else if (!in_range(next_pc)) begin
        state_d  = HALT;
        vld_d    = 1'b0;
        halted_d = 1'b1;
        err_d    = 1'b1;
      end else begin
        pc_d    = next_pc;
        instr_d = rd_fwd;
      end
    end

    // A rejected load is flagged even in a cycle that also restarts.
    if (ld_bad) begin
      err_d = 1'b1;
    end
  end

  // Stage p0: output register holding the presented instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_p0    <= '0;
      instr_p0 <= '0;
      vld_p0   <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_p0    <= pc_d;
      instr_p0 <= instr_d;
      vld_p0   <= vld_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign instr       = instr_p0;
  assign instr_valid = vld_p0;
  assign pc          = pc_p0;
  assign halted      = halted_q;
  assign err         = err_q;

endmodule

// File: tb/tb_prog_fetch_rom.sv
// Scoreboard bench for prog_fetch_rom: directed program scenarios followed by
// randomized traffic, checked against a behavioural model of the fetch rules.
module tb_prog_fetch_rom;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ld_we = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic              abort = 1'b0;
  logic              jmp_en = 1'b0;
  logic [ADDR_W-1:0] jmp_addr = '0;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              err;

  always #5 clk = ~clk;

  prog_fetch_rom #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .start      (start),
    .start_addr (start_addr),
    .abort      (abort),
    .jmp_en     (jmp_en),
    .jmp_addr   (jmp_addr),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc         (pc),
    .halted     (halted),
    .err        (err)
  );

  int checks = 0;
  int errors = 0;

  // Model state: m_* is what the DUT should show now, n_* after the next edge.
  int         m_mode = M_IDLE, n_mode;
  int         m_pc = 0, n_pc;
  logic [7:0] m_instr = 8'h00, n_instr;
  bit         m_vld = 0, n_vld;
  bit         m_halted = 0, n_halted;
  bit         m_err = 0, n_err;
  logic [7:0] m_mem [DEPTH];
  logic [7:0] n_mem [DEPTH];

  logic [ADDR_W+DATA_W-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_next();
    bit load_err;
    int npc;
    n_mode = m_mode; n_pc = m_pc; n_instr = m_instr;
    n_vld = m_vld; n_halted = m_halted; n_err = m_err;
    for (int i = 0; i < DEPTH; i++) n_mem[i] = m_mem[i];
    if (rst) begin
      n_mode = M_IDLE; n_pc = 0; n_instr = 8'h00;
      n_vld = 0; n_halted = 0; n_err = 0;
      for (int i = 0; i < DEPTH; i++) n_mem[i] = 8'hFF;
      return;
    end
    load_err = 0;
    if (ld_we) begin
      if (m_mode == M_RUN || int'(ld_addr) >= DEPTH) load_err = 1;
      else n_mem[ld_addr] = ld_data;
    end
    if (abort) begin
      n_mode = M_IDLE; n_vld = 0; n_halted = 0;
    end else if (start && m_mode != M_RUN) begin
      n_err = 0; n_halted = 0;
      if (int'(start_addr) < DEPTH) begin
        n_mode = M_RUN; n_pc = int'(start_addr); n_instr = n_mem[start_addr]; n_vld = 1;
      end else begin
        n_mode = M_HALT; n_halted = 1; n_err = 1; n_vld = 0;
      end
    end else if (m_mode == M_RUN && m_vld && instr_ready) begin
      if (m_instr == 8'hFF) begin
        n_mode = M_HALT; n_vld = 0; n_halted = 1;
      end else begin
        npc = jmp_en ? int'(jmp_addr) : (m_pc + 1) % DEPTH;
        if (npc >= DEPTH) begin
          n_mode = M_HALT; n_vld = 0; n_halted = 1; n_err = 1;
        end else begin
          n_pc = npc; n_instr = n_mem[npc];
        end
      end
    end
    if (load_err) n_err = 1;
  endtask

  // Issue the current inputs for one clock; expected handshakes go to the scoreboard.
  task automatic tick();
    if (m_vld && instr_ready) exp_q.push_back({ADDR_W'(m_pc), m_instr});
    model_next();
    @(posedge clk);
    #1;
    m_mode = n_mode; m_pc = n_pc; m_instr = n_instr;
    m_vld = n_vld; m_halted = n_halted; m_err = n_err;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = n_mem[i];
  endtask

  task automatic do_load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] a);
    start = 1'b1; start_addr = a;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_out(input string name, input int epc, input logic [7:0] ei);
    check({name, "_valid"}, 32'(instr_valid), 32'd1);
    check({name, "_pc"}, 32'(pc), 32'(epc));
    check({name, "_instr"}, 32'(instr), 32'(ei));
  endtask

  // Monitor: pops on every handshake and tracks the status flags each cycle.
  initial begin
    logic [ADDR_W+DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      if (instr_valid === 1'b1 && instr_ready) begin
        if (exp_q.size() == 0) begin
          check("hs_unexpected", 32'(pc), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("hs_pc", 32'(pc), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
          check("hs_instr", 32'(instr), 32'(e[DATA_W-1:0]));
        end
      end
      check("mon_valid", 32'(instr_valid), 32'(m_vld));
      check("mon_halted", 32'(halted), 32'(m_halted));
      check("mon_err", 32'(err), 32'(m_err));
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'hFF;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Empty store: the first fetched word is HALT.
    instr_ready = 1'b1;
    do_start(4'd0);
    expect_out("empty", 0, 8'hFF);
    tick();
    check("empty_halted", 32'(halted), 32'd1);
    check("empty_valid", 32'(instr_valid), 32'd0);

    // Straight-line program with a jump back to 1 on C1.
    do_load(4'd0, 8'h60);
    do_load(4'd1, 8'h80);
    do_load(4'd2, 8'hA0);
    do_load(4'd3, 8'hC1);
    do_load(4'd4, 8'hFF);
    do_start(4'd0);
    expect_out("seq0", 0, 8'h60);
    tick();
    expect_out("seq1", 1, 8'h80);
    tick();
    expect_out("seq2", 2, 8'hA0);
    tick();
    expect_out("seq3", 3, 8'hC1);
    jmp_en = 1'b1; jmp_addr = 4'd1;
    tick();
    jmp_en = 1'b0;
    expect_out("jmp", 1, 8'h80);
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out("stall", 1, 8'h80);
    end
    instr_ready = 1'b1;
    tick();
    expect_out("release", 2, 8'hA0);
    tick();
    expect_out("seq3b", 3, 8'hC1);
    tick();
    expect_out("seq4", 4, 8'hFF);
    tick();
    check("prog_halted", 32'(halted), 32'd1);

    // PC wraps from DEPTH-1 to 0.
    do_load(4'd15, 8'h60);
    do_load(4'd0, 8'hFF);
    do_start(4'd15);
    expect_out("wrap15", 15, 8'h60);
    tick();
    expect_out("wrap0", 0, 8'hFF);
    tick();
    check("wrap_halted", 32'(halted), 32'd1);

    // Load attempted while running is dropped and flagged.
    do_load(4'd5, 8'h60);
    do_load(4'd6, 8'h60);
    do_load(4'd7, 8'hFF);
    instr_ready = 1'b0;
    do_start(4'd5);
    expect_out("run5", 5, 8'h60);
    do_load(4'd6, 8'h11);
    check("runld_err", 32'(err), 32'd1);
    instr_ready = 1'b1;
    tick();
    expect_out("run6", 6, 8'h60);
    tick();
    expect_out("run7", 7, 8'hFF);
    tick();
    check("runld_halted", 32'(halted), 32'd1);
    check("runld_err_sticky", 32'(err), 32'd1);
    do_start(4'd0);
    check("start_clears_err", 32'(err), 32'd0);
    tick();

    // Write-first on start, then abort wins over a handshake.
    start = 1'b1; start_addr = 4'd2;
    ld_we = 1'b1; ld_addr = 4'd2; ld_data = 8'h80;
    tick();
    start = 1'b0; ld_we = 1'b0;
    expect_out("wfirst", 2, 8'h80);
    tick();
    expect_out("after_wf", 3, 8'hC1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", 32'(instr_valid), 32'd0);
    check("abort_halted", 32'(halted), 32'd0);
    check("abort_pc_hold", 32'(pc), 32'd3);
    check("abort_instr_hold", 32'(instr), 32'hC1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      rst         = ($urandom_range(0, 249) == 0);
      abort       = ($urandom_range(0, 39) == 0);
      start       = ($urandom_range(0, 9) == 0);
      start_addr  = ADDR_W'($urandom);
      ld_we       = ($urandom_range(0, 3) == 0);
      ld_addr     = ADDR_W'($urandom);
      ld_data     = ($urandom_range(0, 6) == 0) ? 8'hFF : 8'($urandom);
      jmp_en      = ($urandom_range(0, 4) == 0);
      jmp_addr    = ADDR_W'($urandom);
      instr_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0; abort = 1'b0; start = 1'b0; ld_we = 1'b0; jmp_en = 1'b0;
    instr_ready = 1'b0;
    tick();
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
